// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks.
//   ACT_LINEAR / ACT_RELU : activation mode selectors for ACT_MODE parameters
//   nn_state_t            : neuron sequencing states (IDLE, MAC, BIAS, OUT)
//   clog2_min1            : ceil(log2(n)) but never less than 1, for index widths
package nn_pkg;

  localparam int ACT_LINEAR = 0;
  localparam int ACT_RELU   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    BIAS = 2'd2,
    OUT  = 2'd3
  } nn_state_t;

  // A single-input neuron still needs a 1-bit index port.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/neuron_mac_stream_if.sv
// Streamed weight channel between a weight source (e.g. ROM) and a neuron.
//   w_valid / w_ready : beat handshake, transfer when both are high
//   w_data            : signed weight for element w_idx
//   w_idx             : index of the weight the neuron expects next; valid
//                       combinationally while w_ready is high so the source
//                       can address its memory from it
// Modports: master = weight source, slave = neuron.
interface neuron_mac_stream_if #(
  parameter int WW = 8,
  parameter int IW = 1
);
  logic                 w_valid;
  logic signed [WW-1:0] w_data;
  logic                 w_ready;
  logic [IW-1:0]        w_idx;

  modport master (output w_valid, output w_data, input w_ready, input w_idx);
  modport slave  (input w_valid, input w_data, output w_ready, output w_idx);
endinterface

// File: rtl/nn_requant.sv
// Combinational requantisation of a neuron accumulator.
//   acc : signed accumulator (bias already added)
//   y   : acc >>> OUT_SHIFT, optional ReLU, saturated to OUT_W signed
//   sat : high when the post-activation value was clipped
module nn_requant
  import nn_pkg::*;
#(
  parameter int ACC_W     = 24,
  parameter int OUT_W     = 8,
  parameter int OUT_SHIFT = 0,
  parameter int ACT_MODE  = ACT_RELU
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);

  // Output range expressed at accumulator width so comparisons stay signed.
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] acted;

  // Arithmetic shift floors toward -inf, which is the intended rounding.
  assign shifted = acc >>> OUT_SHIFT;
  assign acted   = (ACT_MODE == ACT_RELU && shifted < 0) ? '0 : shifted;

  always_comb begin
    y   = acted[OUT_W-1:0];
    sat = 1'b0;
    if (acted > Y_MAX) begin
      y   = Y_MAX[OUT_W-1:0];
      sat = 1'b1;
    end else if (acted < Y_MIN) begin
      y   = Y_MIN[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/neuron_mac_stream.sv
// Single neuron: captures activations and bias on start, accumulates one
// streamed weight per accepted beat, adds bias, requantises and pulses done.
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin an operation (only honoured in IDLE)
//   x_vec, bias  : activations (element i at [i*DW +: DW]) and bias, captured on start
//   w_if         : weight stream (slave side), w_ready high exactly while in MAC
//   busy         : high in any state other than IDLE
//   done         : one-cycle pulse when y / sat are updated
//   y, sat       : saturated result and clip flag, held until the next done
module neuron_mac_stream
  import nn_pkg::*;
#(
  parameter int N_IN      = 32,
  parameter int DW        = 8,
  parameter int WW        = 8,
  parameter int BW        = 8,
  parameter int ACC_W     = 24,
  parameter int OUT_W     = 8,
  parameter int OUT_SHIFT = 0,
  parameter int ACT_MODE  = ACT_RELU
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_IN*DW-1:0]      x_vec,
  input  logic signed [BW-1:0]    bias,
  neuron_mac_stream_if.slave      w_if,
  output logic                    busy,
  output logic                    done,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);

  localparam int IDX_W  = clog2_min1(N_IN);
  localparam int PROD_W = DW + WW;

  // The accumulator must hold N_IN full products plus bias without wrapping.
  if (ACC_W < DW + WW + $clog2(N_IN) + 1 || ACC_W < BW + 1) begin : g_acc_too_narrow
    $error("neuron_mac_stream: ACC_W too narrow for N_IN/DW/WW/BW");
  end

  nn_state_t               state_reg;
  logic signed [DW-1:0]    x_reg [N_IN];
  logic signed [BW-1:0]    bias_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic signed [OUT_W-1:0] y_reg;
  logic                    sat_reg;
  logic                    done_reg;

  logic signed [DW-1:0]    x_in [N_IN];
  logic signed [PROD_W-1:0] prod;
  logic signed [OUT_W-1:0] rq_y;
  logic                    rq_sat;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
    assign x_in[gi] = x_vec[gi*DW +: DW];
  end

  // Full-precision signed product of the current element and weight.
  assign prod = x_reg[idx_reg] * w_if.w_data;

  nn_requant #(
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .OUT_SHIFT(OUT_SHIFT),
    .ACT_MODE (ACT_MODE)
  ) u_requant (
    .acc(acc_reg),
    .y  (rq_y),
    .sat(rq_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      idx_reg   <= '0;
      y_reg     <= '0;
      sat_reg   <= 1'b0;
      done_reg  <= 1'b0;
      bias_reg  <= '0;
      for (int i = 0; i < N_IN; i++) x_reg[i] <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N_IN; i++) x_reg[i] <= x_in[i];
            bias_reg  <= bias;
            acc_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= MAC;
          end
        end
        MAC: begin
          if (w_if.w_valid) begin
            acc_reg <= acc_reg + ACC_W'(prod);
            if (idx_reg == IDX_W'(N_IN - 1)) begin
              idx_reg   <= '0;
              state_reg <= BIAS;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        BIAS: begin
          acc_reg   <= acc_reg + ACC_W'(bias_reg);
          state_reg <= OUT;
        end
        OUT: begin
          y_reg     <= rq_y;
          sat_reg   <= rq_sat;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign w_if.w_ready = (state_reg == MAC);
  assign w_if.w_idx   = idx_reg;
  assign busy         = (state_reg != IDLE);
  assign done         = done_reg;
  assign y            = y_reg;
  assign sat          = sat_reg;

endmodule

// File: doc/neuron_mac_stream.md
Name: neuron_mac_stream

Overview:
- Parametrised single-neuron multiply-accumulate engine for hidden and output layers.
- Captures an N_IN-element signed activation vector and bias on start, then consumes one streamed signed weight per valid/ready beat.
- After the last weight it adds the bias, applies an arithmetic right-shift requantisation and optional ReLU, then saturates to OUT_W.
- Result is presented with a one-cycle done pulse; layer wrappers instantiate one per neuron.

Parameters:
N_IN, 32, number of inputs (>=1)
DW, 8, signed activation width
WW, 8, signed weight width
BW, 8, signed bias width
ACC_W, 24, accumulator width; elaboration error if < DW+WW+clog2(N_IN)+1 or < BW+1
OUT_W, 8, signed output width
OUT_SHIFT, 0, arithmetic right shift applied to the final accumulator (0..ACC_W-1)
ACT_MODE, 1, 0 = linear, 1 = ReLU

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin operation; sampled only in IDLE
x_vec  in  N_IN*DW  signed activations, element i at [i*DW +: DW]; captured on accepted start
bias  in  BW  signed bias; captured on accepted start
w_valid  in  1  weight beat valid
w_data  in  WW  signed weight for element w_idx
w_ready  out  1  high exactly while in MAC
w_idx  out  clog2(N_IN) (min 1)  index of the next expected weight
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when y is updated
y  out  OUT_W  signed result; holds until the next done
sat  out  1  y was clipped this result; updated with y

Behaviour:
- Reset (synchronous, rst=1 at an edge): state IDLE; acc, idx, y, sat, done = 0; captured x and bias = 0. Reset has priority over everything, including mid-operation. An aborted operation produces no done.
- FSM: IDLE -> MAC -> BIAS -> OUT -> IDLE.
- IDLE, start=1:
  - capture x_vec and bias
  - acc <= 0, idx <= 0
  - go to MAC
  - start while busy is ignored.
- MAC, w_valid=1 (w_ready is 1):
  - acc <= acc + x[idx]*w_data, full-precision signed product, sign-extended to ACC_W
  - idx <= idx+1
  - If idx==N_IN-1, go to BIAS instead (idx returns to 0).
  - w_valid=0 stalls with no state change; gaps of any length are legal.
- BIAS: acc <= acc + sign-extended bias; go to OUT.
- OUT:
  - r = acc >>> OUT_SHIFT (floor toward -inf)
  - if ACT_MODE=1 and r<0, r = 0
  - y <= clip(r, -2^(OUT_W-1), 2^(OUT_W-1)-1)
  - sat <= (r was clipped)
  - done <= 1 for one cycle
  - go to IDLE
- done is high in the first IDLE cycle. A start in that same cycle is accepted (back-to-back operation).
- Latency: with w_valid continuously high, done is asserted N_IN+2 cycles after the start-accepting edge. Throughput is one result per N_IN+3 cycles.
- The accumulator never wraps, given the ACC_W constraint.
- w_idx is valid combinationally with w_ready, so the upstream weight ROM can address from it.
- x_vec and bias changes after capture have no effect.

Decomposition:
- Shared package nn_pkg holds:
  - ACT_LINEAR=0 and ACT_RELU=1 constants
  - state encoding typedef (IDLE, MAC, BIAS, OUT)
  - function clog2_min1
- One sub-module, nn_requant (combinational: shift, activation, saturate, sat flag). It is reused by the output-layer neuron.

Test Plan (N_IN=4 unless noted):
1. x={1,2,3,4}, w={1,1,1,1} continuous, bias=-2, ACT_MODE=1 -> done 6 cycles after start edge, y=8, sat=0.
2. x={-5,-5,-5,-5}, w={1,1,1,1}, bias=0: ACT_MODE=1 -> y=0, sat=0; ACT_MODE=0 -> y=-20, sat=0.
3. x all 127, w all 127, bias=0 -> acc=64516, y=127, sat=1. With x all -128, w all 127, ACT_MODE=0 -> y=-128, sat=1.
4. OUT_SHIFT=2, accumulator total -7, ACT_MODE=0 -> y=-2 (floor). Same with ACT_MODE=1 -> y=0.
5. w_valid toggling 1,0,0,1,... with random gaps -> identical y to the continuous case. w_idx steps 0..3 only on accepted beats; start pulses during busy are ignored.
6. rst=1 mid-MAC (after 2 beats) -> next cycle busy=0, y=0, no done. A new start then yields the correct fresh result. Back-to-back start in the done cycle is accepted and the result is correct.
